// File: rtl/alu_pkg.sv
// Shared ALU definitions: iteration-sequencer state encoding and op codes.
package alu_pkg;

  typedef enum logic [1:0] {
    ITER_IDLE  = 2'd0,
    ITER_CLEAR = 2'd1,
    ITER_RUN   = 2'd2,
    ITER_DONE  = 2'd3
  } iter_state_t;

  localparam logic OP_MUL = 1'b0;  // counter counts up
  localparam logic OP_DIV = 1'b1;  // counter counts down

endpackage

// File: rtl/iter_ctrl.sv
// Iteration sequencer for multi-cycle ALU ops. Drives an external up/down
// counter, watches its value for the terminal iteration and issues one
// datapath step per RUN cycle, N_ITER steps per start.
// Optional feature macro: ITER_CTRL_ABORT_EN adds an abort input and an
// aborted pulse output; without it the block has no abort path at all.
module iter_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int N_ITER = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] cnt,
`ifdef ITER_CTRL_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             busy,
  output logic             done,
  output logic             step,
  output logic             last,
  output logic             count_up,
  output logic             count_down,
  output logic             cnt_clr,
  output logic             op_q
);

  localparam int unsigned CNT_MOD = 1 << WIDTH;

  // Terminal counter values; the DIV value wraps modulo 2^WIDTH, so
  // N_ITER = 2^WIDTH in DIV ends at 1 after wrapping from 0.
  localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(N_ITER - 1);
  localparam logic [WIDTH-1:0] TERM_DN = WIDTH'(CNT_MOD - (N_ITER - 1));

  // Reject parameter sets the counter cannot represent.
  if (N_ITER < 1 || N_ITER > (1 << WIDTH)) begin : g_bad_n_iter
    $error("iter_ctrl: N_ITER must be within 1..2^WIDTH");
  end

  iter_state_t state_reg;
  logic        op_q_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        clr_reg;
  logic        in_run;
  logic        term;
  logic        abort_hit;

`ifdef ITER_CTRL_ABORT_EN
  logic        aborted_reg;

  // Abort only matters while the sequencer owns the counter (CLEAR/RUN).
  assign abort_hit = abort & busy_reg;
  assign aborted   = aborted_reg;
`else
  assign abort_hit = 1'b0;
`endif

  assign in_run = (state_reg == ITER_RUN);
  assign term   = (cnt == ((op_q_reg == OP_DIV) ? TERM_DN : TERM_UP));

  // Per-cycle strobes are combinational from state, op_q and cnt so the
  // counter stops exactly on the terminal value.
  assign step       = in_run & ~abort_hit;
  assign last       = in_run & term;
  assign count_up   = step & (op_q_reg == OP_MUL) & ~term;
  assign count_down = step & (op_q_reg == OP_DIV) & ~term;
  assign cnt_clr    = clr_reg | abort_hit;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign op_q       = op_q_reg;

  // Sequencer FSM with registered busy/done/clear outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ITER_IDLE;
      op_q_reg    <= OP_MUL;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      clr_reg     <= 1'b0;
`ifdef ITER_CTRL_ABORT_EN
      aborted_reg <= 1'b0;
`endif
    end else begin
      done_reg    <= 1'b0;
      clr_reg     <= 1'b0;
`ifdef ITER_CTRL_ABORT_EN
      aborted_reg <= 1'b0;
`endif
      unique case (state_reg)
        ITER_IDLE: begin
          if (start) begin
            state_reg <= ITER_CLEAR;
            op_q_reg  <= op;
            busy_reg  <= 1'b1;
            clr_reg   <= 1'b1;
          end
        end
        ITER_CLEAR: begin
          if (abort_hit) begin
            state_reg   <= ITER_IDLE;
            busy_reg    <= 1'b0;
`ifdef ITER_CTRL_ABORT_EN
            aborted_reg <= 1'b1;
`endif
          end else begin
            state_reg <= ITER_RUN;
          end
        end
        ITER_RUN: begin
          if (abort_hit) begin
            state_reg   <= ITER_IDLE;
            busy_reg    <= 1'b0;
`ifdef ITER_CTRL_ABORT_EN
            aborted_reg <= 1'b1;
`endif
          end else if (term) begin
            state_reg <= ITER_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        ITER_DONE: begin
          state_reg <= ITER_IDLE;
        end
        default: begin
          state_reg <= ITER_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_ctrl.sv
// Bench for iter_ctrl: two instances (N_ITER=8 and N_ITER=1) each closing
// the loop through a behavioural up/down counter. Expected counter values
// per step are queued when start is driven and popped on each step.
module tb_iter_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       op;
  logic [3:0] cnt8, cnt1;
  logic       busy8, done8, step8, last8, up8, dn8, clr8, opq8;
  logic       busy1, done1, step1, last1, up1, dn1, clr1, opq1;
`ifdef ITER_CTRL_ABORT_EN
  logic       abort;
  logic       aborted8, aborted1;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  iter_ctrl #(.WIDTH(4), .N_ITER(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .op(op), .cnt(cnt8),
`ifdef ITER_CTRL_ABORT_EN
    .abort(abort), .aborted(aborted8),
`endif
    .busy(busy8), .done(done8), .step(step8), .last(last8),
    .count_up(up8), .count_down(dn8), .cnt_clr(clr8), .op_q(opq8)
  );

  iter_ctrl #(.WIDTH(4), .N_ITER(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .cnt(cnt1),
`ifdef ITER_CTRL_ABORT_EN
    .abort(abort), .aborted(aborted1),
`endif
    .busy(busy1), .done(done1), .step(step1), .last(last1),
    .count_up(up1), .count_down(dn1), .cnt_clr(clr1), .op_q(opq1)
  );

  // Behavioural counters as the parent would wire them.
  always @(posedge clk) begin
    if (reset || clr8)  cnt8 <= 4'd0;
    else if (up8)       cnt8 <= cnt8 + 4'd1;
    else if (dn8)       cnt8 <= cnt8 - 4'd1;
    if (reset || clr1)  cnt1 <= 4'd0;
    else if (up1)       cnt1 <= cnt1 + 4'd1;
    else if (dn1)       cnt1 <= cnt1 - 4'd1;
  end

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; op = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cmp_cnt++;
    if ({busy8, done8, step8, last8, up8, dn8, clr8, opq8} !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset_outs8: got %b want 00000000",
               {busy8, done8, step8, last8, up8, dn8, clr8, opq8});
    end
    cmp_cnt++;
    if ({busy1, done1, step1, last1, up1, dn1, clr1, opq1} !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset_outs1: got %b want 00000000",
               {busy1, done1, step1, last1, up1, dn1, clr1, opq1});
    end
  endtask

  // One operation on the N_ITER=8 instance; optionally pokes start during
  // RUN and in the DONE cycle, which must both be ignored.
  task automatic run_op(input logic op_v, input bit poke_start);
    int  steps;
    int  lat;
    logic [3:0] e;
    logic [3:0] term_v;
    steps  = 0;
    lat    = 0;
    term_v = op_v ? 4'd9 : 4'd7;
    for (int i = 0; i < 8; i++) exp_q.push_back(op_v ? 4'(16 - i) : 4'(i));
    @(negedge clk);
    start = 1'b1; op = op_v;
    @(negedge clk);
    start = 1'b0; op = ~op_v;
    cmp_cnt++;
    if ({busy8, clr8, step8, opq8} !== {1'b1, 1'b1, 1'b0, op_v}) begin
      err_cnt++;
      $display("FAIL clear_cycle: got busy/clr/step/opq=%b want %b",
               {busy8, clr8, step8, opq8}, {1'b1, 1'b1, 1'b0, op_v});
    end
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (step8) begin
        steps++;
        if (exp_q.size() == 0) begin
          cmp_cnt++; err_cnt++;
          $display("FAIL step_overrun: got step %0d want at most 8", steps);
        end else begin
          e = exp_q.pop_front();
          cmp_cnt++;
          if (cnt8 !== e) begin
            err_cnt++;
            $display("FAIL step_cnt: got %0d want %0d", cnt8, e);
          end
          cmp_cnt++;
          if ({last8, up8, dn8} !== {exp_q.size() == 0,
                                     !op_v && exp_q.size() != 0,
                                     op_v && exp_q.size() != 0}) begin
            err_cnt++;
            $display("FAIL step_ctl: got last/up/dn=%b at step %0d (op=%0b)",
                     {last8, up8, dn8}, steps, op_v);
          end
        end
      end
      if (done8) begin
        lat = c;
        start = poke_start;
        break;
      end
      start = poke_start && (c == 5);
    end
    cmp_cnt++;
    if (lat !== 10) begin
      err_cnt++;
      $display("FAIL done_latency: got %0d want 10", lat);
    end
    cmp_cnt++;
    if ({busy8, cnt8} !== {1'b0, term_v}) begin
      err_cnt++;
      $display("FAIL done_state: got busy=%b cnt=%0d want busy=0 cnt=%0d",
               busy8, cnt8, term_v);
    end
    cmp_cnt++;
    if (steps !== 8) begin
      err_cnt++;
      $display("FAIL step_count: got %0d want 8", steps);
    end
    exp_q.delete();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if ({busy8, clr8, done8, cnt8} !== {3'b000, term_v}) begin
      err_cnt++;
      $display("FAIL post_done_idle: got busy/clr/done=%b cnt=%0d want 000 cnt=%0d",
               {busy8, clr8, done8}, cnt8, term_v);
    end
    $display("op=%0b steps=%0d latency=%0d final_cnt=%0d", op_v, steps, lat, cnt8);
  endtask

  task automatic test_mul();
    run_op(OP_MUL, 1'b0);
  endtask

  task automatic test_div();
    run_op(OP_DIV, 1'b0);
  endtask

  task automatic test_ignore_start();
    run_op(OP_MUL, 1'b1);
  endtask

  task automatic test_n1();
    int  steps;
    int  lat;
    bit  up_seen;
    steps = 0; lat = 0; up_seen = 1'b0;
    exp_q.push_back(4'd0);
    @(negedge clk);
    start = 1'b1; op = OP_MUL;
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (up1) up_seen = 1'b1;
      if (step1) begin
        steps++;
        cmp_cnt++;
        if (exp_q.size() == 0 || cnt1 !== exp_q[0] || last1 !== 1'b1) begin
          err_cnt++;
          $display("FAIL n1_step: got cnt=%0d last=%b want cnt=0 last=1", cnt1, last1);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (done1) begin
        lat = c;
        break;
      end
    end
    cmp_cnt++;
    if ({steps, lat} !== {32'd1, 32'd3}) begin
      err_cnt++;
      $display("FAIL n1_run: got steps=%0d latency=%0d want 1 and 3", steps, lat);
    end
    cmp_cnt++;
    if (up_seen !== 1'b0) begin
      err_cnt++;
      $display("FAIL n1_count_up: got asserted want never");
    end
    exp_q.delete();
    $display("n1 op=0 steps=%0d latency=%0d", steps, lat);
    // let the N_ITER=8 instance, started alongside, finish
    for (int c = 0; c < 12; c++) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit got_done;
    got_done = 1'b0;
    @(negedge clk);
    start = 1'b1; op = OP_MUL;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done8) begin
        got_done = 1'b1;
        break;
      end
    end
    cmp_cnt++;
    if (!got_done) begin
      err_cnt++;
      $display("FAIL b2b_done: got no done within 20 cycles want done");
    end
    @(negedge clk);
    cmp_cnt++;
    if ({busy8, clr8} !== 2'b00) begin
      err_cnt++;
      $display("FAIL b2b_gap: got busy/clr=%b want 00", {busy8, clr8});
    end
    @(negedge clk);
    start = 1'b0;
    cmp_cnt++;
    if ({busy8, clr8} !== 2'b11) begin
      err_cnt++;
      $display("FAIL b2b_reclear: got busy/clr=%b want 11", {busy8, clr8});
    end
    $display("back_to_back second op started");
    for (int c = 0; c < 12; c++) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 1'b0;
    @(negedge clk);
    start = 1'b1; op = OP_MUL;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (step8 && cnt8 == 4'd4) begin
        hit = 1'b1;
        break;
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cmp_cnt++;
    if (!hit || {busy8, done8, step8, last8, up8, dn8, clr8, opq8} !== 8'h00
        || cnt8 !== 4'd0) begin
      err_cnt++;
      $display("FAIL reset_mid: got hit=%b outs=%b cnt=%0d want 1 00000000 0", hit,
               {busy8, done8, step8, last8, up8, dn8, clr8, opq8}, cnt8);
    end
    $display("reset_mid applied at cnt=4");
    run_op(OP_MUL, 1'b0);
  endtask

`ifdef ITER_CTRL_ABORT_EN
  task automatic test_abort();
    bit hit;
    bit done_seen;
    hit = 1'b0; done_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; op = OP_MUL;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (step8 && cnt8 == 4'd3) begin
        hit = 1'b1;
        break;
      end
    end
    abort = 1'b1;
    #1;
    cmp_cnt++;
    if (!hit || {clr8, step8, up8, dn8} !== 4'b1000) begin
      err_cnt++;
      $display("FAIL abort_cycle: got hit=%b clr/step/up/dn=%b want 1 1000", hit,
               {clr8, step8, up8, dn8});
    end
    @(negedge clk);
    abort = 1'b0;
    cmp_cnt++;
    if ({aborted8, busy8, done8} !== 3'b100) begin
      err_cnt++;
      $display("FAIL abort_pulse: got aborted/busy/done=%b want 100",
               {aborted8, busy8, done8});
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done8) done_seen = 1'b1;
    end
    cmp_cnt++;
    if ({done_seen, aborted8, busy8} !== 3'b000) begin
      err_cnt++;
      $display("FAIL abort_after: got done_seen/aborted/busy=%b want 000",
               {done_seen, aborted8, busy8});
    end
    $display("abort at cnt=3 handled");
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
`ifdef ITER_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_mul();
    test_div();
    test_reset();
    test_n1();
    test_reset();
    test_ignore_start();
    test_back_to_back();
    test_reset();
    test_reset_mid();
`ifdef ITER_CTRL_ABORT_EN
    test_reset();
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion want finish before 200000");
    $fatal(1, "time limit reached");
  end

endmodule
